// File: rtl/bch_pkg.sv
// Shared BCH(15,7) constants, GF(2^4) tables and encoder state type.
// Used by the serial encoder and the decode-side syndrome block.
package bch_pkg;

  localparam int N  = 15;
  localparam int K  = 7;
  localparam int NK = 8;

  // g(x) = x^8+x^7+x^6+x^4+1, product of the minimal polys of alpha and alpha^3
  localparam logic [8:0] GEN_POLY  = 9'h1D1;
  // GF(2^4) field polynomial x^4+x+1
  localparam logic [4:0] PRIM_POLY = 5'h13;

  // antilog: GF_EXP[i] = alpha^i; entry 15 wraps back to alpha^0
  localparam logic [3:0] GF_EXP [0:15] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1
  };

  // log: GF_LOG[a] = i with alpha^i = a; entry 0 is a don't-care
  localparam logic [3:0] GF_LOG [0:15] = '{
    4'h0, 4'h0, 4'h1, 4'h4, 4'h2, 4'h8, 4'h5, 4'hA,
    4'h3, 4'hE, 4'h9, 4'h7, 4'h6, 4'hD, 4'hB, 4'hC
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bch_state_e;

  function automatic logic [3:0] gf_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] s;
    s = {1'b0, GF_LOG[a]} + {1'b0, GF_LOG[b]};
    if (s >= 5'd15) s = s - 5'd15;
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return GF_EXP[s[3:0]];
  endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// Serial divide-by-g(x) LFSR producing the 8-bit BCH parity remainder.
// Ports: clk, rst (sync), clr (zero remainder), en (shift bit_in), rem.
module bch_parity_lfsr
  import bch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [NK-1:0] rem
);

  logic [NK-1:0] rem_q;
  logic [NK-1:0] rem_d;
  logic          fb;

  // message enters at x^8, so feedback is input bit xor the top stage
  always_comb begin
    rem_d = rem_q;
    fb    = bit_in ^ rem_q[NK-1];
    if (clr) begin
      rem_d = '0;
    end else if (en) begin
      rem_d = {rem_q[NK-2:0], 1'b0}
            ^ (fb ? GEN_POLY[NK-1:0] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

  assign rem = rem_q;

endmodule

// File: rtl/bch_encoder_serial.sv
// Systematic BCH(15,7) encoder, one message bit per clock, MSB first.
// Ports: clk, rst (sync), in_valid/in_ready/in_msg, out_valid/out_ready/out_codeword, busy.
module bch_encoder_serial
  import bch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_msg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_codeword,
  output logic          busy
);

  bch_state_e    state_q;
  bch_state_e    state_d;
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_d;
  logic [K-1:0]  msg_q;
  logic [K-1:0]  msg_d;
  logic          accept;
  logic          shift_en;
  logic          msg_bit;
  logic [NK-1:0] rem;

  assign shift_en = (state_q == SHIFT);
  assign msg_bit  = msg_q[3'd6 - cnt_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          msg_d   = in_msg;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 3'd6) begin
          cnt_d   = 3'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
    end
  end

  bch_parity_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (shift_en),
    .bit_in (msg_bit),
    .rem    (rem)
  );

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_codeword = {msg_q, rem};

endmodule

// File: tb/tb_bch_encoder_serial.sv
// Self-checking bench for bch_encoder_serial against a polynomial-division
// and GF(2^4) syndrome reference model.
module tb_bch_encoder_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_msg;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_codeword;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int gexp [15];

  always #5 clk = ~clk;

  bch_encoder_serial dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_msg       (in_msg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .busy         (busy)
  );

  // codeword = m(x)*x^8 + (m(x)*x^8 mod g(x)) by long division
  function automatic logic [14:0] ref_cw(input logic [6:0] m);
    int d;
    d = int'(m) << 8;
    for (int i = 14; i >= 8; i--)
      if (((d >> i) & 1) == 1) d = d ^ ('h1D1 << (i - 8));
    return 15'((int'(m) << 8) | (d & 'hFF));
  endfunction

  // S_j = c(alpha^j)
  function automatic int syn(input logic [14:0] c, input int j);
    int s;
    s = 0;
    for (int i = 0; i < 15; i++)
      if (c[i]) s = s ^ gexp[(i * j) % 15];
    return s;
  endfunction

  task automatic do_word(input logic [6:0] m, input int bp,
                         output logic [14:0] cw, output int lat);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_msg    = m;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    repeat (bp) @(negedge clk);
    cw = out_codeword;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_msg = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_codeword !== 15'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/busy=%b cw=%h required 100 cw=0000",
               {in_ready, out_valid, busy}, out_codeword);
    end
    rst = 1'b0;
  endtask

  task automatic test_known();
    logic [6:0]  msgs [3] = '{7'h00, 7'h01, 7'h7F};
    logic [14:0] exps [3] = '{15'h0000, 15'h01D1, 15'h7FFF};
    logic [14:0] cw;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_word(msgs[i], 0, cw, lat);
      checks++;
      if (cw !== exps[i]) begin
        errors++;
        $display("FAIL known_cw msg=%h: got %h required %h", msgs[i], cw, exps[i]);
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL latency msg=%h: got %0d required 8", msgs[i], lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  expq [$];
    logic [6:0]  m;
    logic [14:0] cw;
    int idx = 0, got = 0, cyc = 0, last_acc = -1, bad;
    bit acc_prev = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_msg = 7'h00;
    while (got < 128 && cyc < 128 * 9 + 200) begin
      if (acc_prev) begin
        acc_prev = 0;
        idx++;
        if (idx < 128) in_msg = 7'(idx);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        cw = out_codeword;
        m = (expq.size() > 0) ? expq.pop_front() : 7'h00;
        got++;
        checks++;
        if (cw !== ref_cw(m)) begin
          errors++;
          $display("FAIL b2b_cw msg=%h: got %h required %h", m, cw, ref_cw(m));
        end
        checks++;
        if (syn(cw, 1) != 0 || syn(cw, 2) != 0 || syn(cw, 3) != 0) begin
          errors++;
          $display("FAIL syndrome cw=%h: S1=%0h S2=%0h S3=%0h required 0",
                   cw, syn(cw, 1), syn(cw, 2), syn(cw, 3));
        end
        bad = 0;
        for (int b = 0; b < 15; b++)
          if (syn(cw ^ (15'h1 << b), 1) == 0) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL flip_s1 cw=%h: zero-S1 flips=%0d required 0", cw, bad);
        end
      end
      if (in_valid && in_ready) begin
        acc_prev = 1;
        expq.push_back(in_msg);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 9) begin
            errors++;
            $display("FAIL throughput: gap %0d required 9", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got != 128) begin
      errors++;
      $display("FAIL b2b_count: got %0d words required 128", got);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [6:0]  m;
    logic [14:0] cw0;
    int n, bad;
    m = 7'($urandom_range(0, 127));
    @(negedge clk);
    in_valid = 1'b1;
    in_msg = m;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    cw0 = out_codeword;
    checks++;
    if (!out_valid || cw0 !== ref_cw(m)) begin
      errors++;
      $display("FAIL bp_first: vld=%b cw=%h required 1 %h", out_valid, cw0, ref_cw(m));
    end
    in_valid = 1'b1;
    in_msg = ~m;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || out_codeword !== cw0 || in_ready || !busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles required 0", bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_codeword !== cw0) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b cw=%h required 0 1 %h",
               out_valid, in_ready, out_codeword, cw0);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [14:0] cw;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_msg = 7'h55;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset: rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
    end
    rst = 1'b0;
    out_ready = 1'b0;
    do_word(7'h01, 0, cw, lat);
    checks++;
    if (cw !== 15'h01D1) begin
      errors++;
      $display("FAIL post_reset_cw: got %h required 01d1", cw);
    end
  endtask

  task automatic test_random();
    logic [6:0]  m;
    logic [14:0] cw;
    int lat;
    for (int i = 0; i < 30; i++) begin
      m = 7'($urandom_range(0, 127));
      do_word(m, int'($urandom_range(0, 5)), cw, lat);
      checks++;
      if (cw !== ref_cw(m) || lat != 8) begin
        errors++;
        $display("FAIL random msg=%h: cw=%h lat=%0d required %h 8", m, cw, lat, ref_cw(m));
      end
    end
  endtask

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 'h13;
    end
    test_reset();
    test_known();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
